// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control FSM: state encodings,
// opcodes and datapath mux/ALU codes.
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_ALU_WB   = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_TRAP     = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the sequencing FSM (master) and the shared
// datapath (slave).
interface mc_ctrl_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       instr_done;
    logic       trap;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done,
               trap, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done,
               trap, state
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles; flags when the count reaches the
// configured timeout.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic inc,
    output logic timeout
);
    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign timeout = (count == CNT_W'(MEM_TIMEOUT));
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V sequencer: one datapath micro-step per cycle for LD, SD,
// BEQ and R-type, with memory-ready stalls and a trap state.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.master  bus
);
    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       wait_state;
    logic       stall;
    logic       timeout;
    logic       timer_clear;

    assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                         (state_q == S_MEM_WR);
    assign stall       = wait_state && !bus.mem_ready;
    assign timer_clear = rst || (state_d != state_q);

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .clear   (timer_clear),
        .inc     (stall),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE)
                    state_d = S_MEM_ADDR;
                else if (bus.opcode == OP_RTYPE)
                    state_d = S_EXEC;
                else if (bus.opcode == OP_BRANCH)
                    state_d = S_BRANCH;
                else
                    state_d = S_TRAP;
            end
            // Opcode is held by the IR, so load/store is simply re-decoded here.
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LOAD)
                    state_d = S_MEM_RD;
                else if (bus.opcode == OP_STORE)
                    state_d = S_MEM_WR;
                else
                    state_d = S_TRAP;
            end
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        // A ready in the timeout cycle still completes normally.
        if (stall && timeout)
            state_d = S_TRAP;
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = SRC_A_PC;
        bus.alu_src_b  = SRC_B_RS2;
        bus.alu_op     = ALU_OP_ADD;
        bus.pc_src     = 1'b0;
        bus.instr_done = 1'b0;
        bus.trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRC_B_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = SRC_A_OLD_PC;
                bus.alu_src_b = SRC_B_IMM;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            S_EXEC: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_RS2;
                bus.alu_op    = ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a  = SRC_A_RS1;
                bus.alu_src_b  = SRC_B_RS2;
                bus.alu_op     = ALU_OP_SUB;
                bus.pc_src     = 1'b1;
                bus.pc_write   = bus.zero;
                bus.instr_done = 1'b1;
            end
            S_TRAP:  bus.trap = 1'b1;
            default: ;
        endcase
    end

    assign bus.state = state_q;
endmodule
